// File: rtl/asteroid_field.sv
// asteroid_field: 8-lane dodge game. It spawns asteroids on a timer, scores lanes that wrap, and ends the game on a player collision.
// Lane selection is round-robin by default; define ASTEROID_LFSR_SPAWN_EN to pick lanes from an 8-bit LFSR instead.
module asteroid_field #(
  parameter int SPAWN_PERIOD = 50000000,
  parameter int SCORE_W      = 8
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        row_pos,
  input  logic [2:0]         player_col,
  output logic [7:0]         enable_count,
  output logic [255:0]       red_pixels,
  output logic [255:0]       green_pixels,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);
  localparam int TW = $clog2(SPAWN_PERIOD);
  localparam logic [TW-1:0] T_LAST = TW'(SPAWN_PERIOD - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {IDLE, PLAY, HIT} state_t;
  state_t state_q, state_d;

  logic [TW-1:0]      timer_q, timer_d;
  logic [7:0]         en_q, en_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [31:0]        prev_q;
  logic [255:0]       red_q, red_d, green_q, green_d;
  logic               game_over_q;
  logic [2:0]         sel;
  logic               spawn, collide, play_entry;
  logic [7:0]         wrap;
  logic [3:0]         wrap_cnt;
  logic [SCORE_W+3:0] score_sum;

  assign collide    = (state_q == PLAY) && en_q[player_col] && (row_pos[player_col*4 +: 4] == 4'hF);
  assign spawn      = (state_q == PLAY) && !collide && (timer_q == T_LAST);
  assign play_entry = (state_q != PLAY) && (state_d == PLAY);

`ifdef ASTEROID_LFSR_SPAWN_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge CLK) begin
    if (reset)      lfsr_q <= 8'h01;
    else if (spawn) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign sel = lfsr_q[2:0];
`else
  logic [2:0] ptr_q;
  always_ff @(posedge CLK) begin
    if (reset)           ptr_q <= 3'd0;
    else if (play_entry) ptr_q <= 3'd0;
    else if (spawn)      ptr_q <= ptr_q + 3'd1;
  end
  assign sel = ptr_q;
`endif

  // A lane wraps when its counter rolls 15 -> 0 while still enabled.
  always_comb begin
    wrap     = '0;
    wrap_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      wrap[i]  = en_q[i] && (prev_q[4*i +: 4] == 4'hF) && (row_pos[4*i +: 4] == 4'h0);
      wrap_cnt = wrap_cnt + {3'b000, wrap[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HIT: if (start) state_d = PLAY;
      PLAY:      if (collide) state_d = HIT;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d   = '0;
    en_d      = '0;
    score_d   = score_q;
    score_sum = {4'b0000, score_q} + {{SCORE_W{1'b0}}, wrap_cnt};
    if (play_entry) begin
      score_d = '0;
    end else if (state_q == PLAY && !collide) begin
      timer_d = spawn ? '0 : timer_q + 1'b1;
      // Spawn ORs in after wrap clears, so a same-lane wrap+spawn leaves the lane enabled.
      en_d    = (en_q & ~wrap) | (spawn ? (8'h01 << sel) : 8'h00);
      score_d = (score_sum > {4'b0000, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end
  end

  // Pixels are built from the state being entered, so they change on the same edge as the state register.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    green_d[240 + 2*player_col +: 2] = 2'b11;
    case (state_d)
      HIT:  red_d[255:240] = '1;
      PLAY: begin
        for (int i = 0; i < 8; i++)
          if (en_d[i]) red_d[16*row_pos[4*i +: 4] + 2*i +: 2] = 2'b11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      timer_q     <= '0;
      en_q        <= '0;
      score_q     <= '0;
      prev_q      <= '0;
      red_q       <= '0;
      green_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      en_q        <= en_d;
      score_q     <= score_d;
      prev_q      <= row_pos;
      red_q       <= red_d;
      green_q     <= green_d;
      game_over_q <= (state_d == HIT);
    end
  end

  assign enable_count = en_q;
  assign red_pixels   = red_q;
  assign green_pixels = green_q;
  assign score        = score_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_asteroid_field.sv
// Bench for asteroid_field (SPAWN_PERIOD=4, round-robin lanes): directed scenarios plus random play against a behavioural game model.
module tb_asteroid_field;
  localparam int SP   = 4;
  localparam int SMAX = 255;
  localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2;

  logic         CLK = 1'b0;
  logic         reset, start;
  logic [31:0]  row_pos;
  logic [2:0]   player_col;
  logic [7:0]   enable_count;
  logic [255:0] red_pixels, green_pixels;
  logic [7:0]   score;
  logic         game_over;

  int total = 0;
  int bad   = 0;

  int           m_state;
  bit           m_en[8];
  int           m_score, m_timer, m_ptr;
  int           m_prev[8];
  logic [255:0] m_red, m_green;
  bit           m_go;

  asteroid_field #(.SPAWN_PERIOD(SP), .SCORE_W(8)) dut (
    .CLK(CLK), .reset(reset), .start(start), .row_pos(row_pos), .player_col(player_col),
    .enable_count(enable_count), .red_pixels(red_pixels), .green_pixels(green_pixels),
    .score(score), .game_over(game_over)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] m_en_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_en[i];
    return v;
  endfunction

  // Game rules applied to the inputs present just before the coming edge.
  task automatic model_step();
    int rows[8];
    int nstate, wraps, pc;
    pc = int'(player_col);
    for (int i = 0; i < 8; i++) rows[i] = int'(row_pos[4*i +: 4]);
    if (reset) begin
      m_state = M_IDLE; m_score = 0; m_timer = 0; m_ptr = 0;
      for (int i = 0; i < 8; i++) m_en[i] = 0;
      m_red = '0; m_green = '0; m_go = 0;
      for (int i = 0; i < 8; i++) m_prev[i] = 0;
      return;
    end
    nstate = m_state;
    if (m_state != M_PLAY) begin
      for (int i = 0; i < 8; i++) m_en[i] = 0;
      m_timer = 0;
      if (start) begin nstate = M_PLAY; m_score = 0; m_ptr = 0; end
    end else if (m_en[pc] && rows[pc] == 15) begin
      nstate = M_HIT;
      for (int i = 0; i < 8; i++) m_en[i] = 0;
      m_timer = 0;
    end else begin
      wraps = 0;
      for (int i = 0; i < 8; i++)
        if (m_en[i] && m_prev[i] == 15 && rows[i] == 0) begin m_en[i] = 0; wraps++; end
      if (m_timer == SP - 1) begin
        m_en[m_ptr] = 1; m_ptr = (m_ptr + 1) % 8; m_timer = 0;
      end else m_timer++;
      m_score = (m_score + wraps > SMAX) ? SMAX : m_score + wraps;
    end
    m_red = '0; m_green = '0;
    m_green[240 + 2*pc] = 1'b1; m_green[241 + 2*pc] = 1'b1;
    if (nstate == M_HIT) begin
      for (int c = 0; c < 16; c++) m_red[240 + c] = 1'b1;
    end else if (nstate == M_PLAY) begin
      for (int i = 0; i < 8; i++)
        if (m_en[i]) begin m_red[16*rows[i] + 2*i] = 1'b1; m_red[16*rows[i] + 2*i + 1] = 1'b1; end
    end
    m_go = (nstate == M_HIT);
    m_state = nstate;
    for (int i = 0; i < 8; i++) m_prev[i] = rows[i];
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_row(input int lane, input int val);
    row_pos[4*lane +: 4] = 4'(val);
  endtask

  // Emulates the external row counters from the model's lane enables.
  task automatic advance_rows(input logic [7:0] adv);
    for (int i = 0; i < 8; i++) begin
      if (!m_en[i])    row_pos[4*i +: 4] = 4'h0;
      else if (adv[i]) row_pos[4*i +: 4] = row_pos[4*i +: 4] + 4'h1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; row_pos = '0; player_col = 3'd0;
    step(); step();
    total++; if (enable_count !== 8'h00) begin bad++; $display("FAIL reset_en got=%h exp=00", enable_count); end
    total++; if (score !== 8'h00) begin bad++; $display("FAIL reset_score got=%0d exp=0", score); end
    total++; if (red_pixels !== '0 || green_pixels !== '0) begin bad++; $display("FAIL reset_pix red=%h green=%h exp=0", red_pixels, green_pixels); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_go got=%b exp=0", game_over); end
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_spawn();
    player_col = 3'd7; row_pos = '0; start = 1'b1;
    step(); start = 1'b0;
    total++; if (enable_count !== 8'h00 || game_over !== 1'b0) begin bad++; $display("FAIL play_entry en=%h go=%b exp=00/0", enable_count, game_over); end
    repeat (4) step();
    total++; if (enable_count !== 8'h01) begin bad++; $display("FAIL spawn1 got=%h exp=01", enable_count); end
    repeat (4) step();
    total++; if (enable_count !== 8'h03) begin bad++; $display("FAIL spawn2 got=%h exp=03", enable_count); end
  endtask

  task automatic test_wrap();
    player_col = 3'd3;
    set_row(0, 15); step();
    set_row(0, 0);  step();
    total++; if (enable_count !== 8'h02) begin bad++; $display("FAIL wrap_en got=%h exp=02", enable_count); end
    total++; if (score !== 8'd1) begin bad++; $display("FAIL wrap_score got=%0d exp=1", score); end
  endtask

  task automatic test_collision();
    player_col = 3'd2;
    step(); step();
    total++; if (enable_count !== 8'h06) begin bad++; $display("FAIL pre_hit_en got=%h exp=06", enable_count); end
    set_row(2, 15); step();
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL hit_go got=%b exp=1", game_over); end
    total++; if (enable_count !== 8'h00) begin bad++; $display("FAIL hit_en got=%h exp=00", enable_count); end
    total++; if (red_pixels[255:240] !== 16'hFFFF || red_pixels[239:0] !== '0) begin bad++; $display("FAIL hit_red got=%h", red_pixels); end
    row_pos = '0; step(); step();
    total++; if (game_over !== 1'b1 || score !== 8'd1) begin bad++; $display("FAIL hit_hold go=%b score=%0d exp=1/1", game_over, score); end
  endtask

  task automatic test_restart();
    logic [255:0] g;
    g = '0; g[245:244] = 2'b11;
    start = 1'b1; step(); start = 1'b0;
    total++; if (game_over !== 1'b0 || score !== 8'd0 || enable_count !== 8'h00) begin bad++; $display("FAIL restart go=%b score=%0d en=%h exp=0/0/00", game_over, score, enable_count); end
    total++; if (green_pixels !== g) begin bad++; $display("FAIL restart_green got=%h exp=%h", green_pixels, g); end
  endtask

  task automatic test_multi_wrap();
    player_col = 3'd7;
    repeat (24) step();
    total++; if (enable_count !== 8'h3F) begin bad++; $display("FAIL mw_pre_en got=%h exp=3f", enable_count); end
    set_row(1, 15); set_row(5, 15); start = 1'b1; step(); start = 1'b0;
    set_row(1, 0);  set_row(5, 0);  step();
    total++; if (score !== 8'd2) begin bad++; $display("FAIL mw_score got=%0d exp=2", score); end
    total++; if (enable_count !== 8'h1D) begin bad++; $display("FAIL mw_en got=%h exp=1d", enable_count); end
  endtask

  task automatic test_saturate();
    reset = 1'b1; step(); reset = 1'b0;
    row_pos = '0; player_col = 3'd7; start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 1600; c++) begin
      advance_rows(8'h7F);
      step();
      total++; if (score !== 8'(m_score)) begin bad++; $display("FAIL sat_score cyc=%0d got=%0d exp=%0d", c, score, m_score); end
      total++; if (enable_count !== m_en_vec()) begin bad++; $display("FAIL sat_en cyc=%0d got=%h exp=%h", c, enable_count, m_en_vec()); end
    end
    total++; if (score !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d exp=255", score); end
  endtask

  task automatic test_reset_midgame();
    reset = 1'b1; step(); reset = 1'b0;
    row_pos = '0; player_col = 3'd7; start = 1'b1; step(); start = 1'b0;
    repeat (32) step();
    total++; if (enable_count !== 8'hFF) begin bad++; $display("FAIL mid_pre_en got=%h exp=ff", enable_count); end
    set_row(0, 15); step(); set_row(0, 0); step();
    total++; if (score !== 8'd1) begin bad++; $display("FAIL mid_pre_score got=%0d exp=1", score); end
    reset = 1'b1; start = 1'b1; step(); reset = 1'b0; start = 1'b0;
    total++; if (enable_count !== 8'h00 || score !== 8'd0 || game_over !== 1'b0) begin bad++; $display("FAIL mid_rst en=%h score=%0d go=%b exp=0", enable_count, score, game_over); end
    total++; if (red_pixels !== '0 || green_pixels !== '0) begin bad++; $display("FAIL mid_rst_pix red=%h green=%h exp=0", red_pixels, green_pixels); end
    row_pos = '0; start = 1'b1; step(); start = 1'b0;
    total++; if (score !== 8'd0 || enable_count !== 8'h00 || game_over !== 1'b0) begin bad++; $display("FAIL mid_restart score=%0d en=%h go=%b exp=0", score, enable_count, game_over); end
  endtask

  task automatic test_random();
    logic [7:0] adv;
    reset = 1'b1; step(); reset = 1'b0;
    row_pos = '0;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) player_col = 3'($urandom_range(0, 7));
      adv = 8'($urandom() | $urandom());
      advance_rows(adv);
      step();
      total++; if (enable_count !== m_en_vec()) begin bad++; $display("FAIL rnd_en cyc=%0d got=%h exp=%h", c, enable_count, m_en_vec()); end
      total++; if (score !== 8'(m_score)) begin bad++; $display("FAIL rnd_score cyc=%0d got=%0d exp=%0d", c, score, m_score); end
      total++; if (game_over !== m_go) begin bad++; $display("FAIL rnd_go cyc=%0d got=%b exp=%b", c, game_over, m_go); end
      total++; if (red_pixels !== m_red) begin bad++; $display("FAIL rnd_red cyc=%0d got=%h exp=%h", c, red_pixels, m_red); end
      total++; if (green_pixels !== m_green) begin bad++; $display("FAIL rnd_green cyc=%0d got=%h exp=%h", c, green_pixels, m_green); end
    end
    reset = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_wrap();
    test_collision();
    test_restart();
    test_multi_wrap();
    test_saturate();
    test_reset_midgame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/asteroid_field.md
ASTEROID_FIELD -- requirements
Module: asteroid_field

Interface
REQ-001 The block SHALL have parameter SPAWN_PERIOD, default 50000000, meaning the number of CLK cycles between spawn attempts (minimum 2).
REQ-002 The block SHALL have parameter SCORE_W, default 8, meaning the score width in bits.
REQ-003 The block SHALL use reset reset, synchronous, active-high; clock CLK.
REQ-004 Port CLK, input, 1, system clock.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port start, input, 1, single-cycle request to begin a game.
REQ-007 Port row_pos, input, 32, row index of lane i's asteroid from its row counter; lane i occupies bits [4i+3:4i], for i = 0..7.
REQ-008 Port player_col, input, 3, lane currently occupied by the player.
REQ-009 Port enable_count, output, 8, per-lane enable for the row counters; a low bit holds that counter at 0.
REQ-010 Port red_pixels, output, 256, asteroid image for the 16x16 board; bit 16r+c is row r, column c.
REQ-011 Port green_pixels, output, 256, player image, with the same bit layout as red_pixels.
REQ-012 Port score, output, SCORE_W, number of asteroids dodged.
REQ-013 Port game_over, output, 1, high while in state HIT.

Function
REQ-014 The FSM SHALL have states IDLE, PLAY and HIT; it transitions IDLE->PLAY and HIT->PLAY on start.
REQ-015 On entry to PLAY: score, spawn timer and lane enables SHALL be cleared.
REQ-016 Collision: in PLAY, if enable_count[player_col]=1 and that lane's row_pos=15, the FSM SHALL enter HIT on the next edge.
REQ-017 Collision SHALL take priority over a same-cycle wrap or spawn.
REQ-018 In IDLE and HIT, enable_count SHALL be 0 and the spawn timer SHALL be held at 0.
REQ-019 Spawn timer: in PLAY it SHALL count 0..SPAWN_PERIOD-1 and then wrap to 0.
REQ-020 A spawn attempt SHALL occur on the cycle the timer equals SPAWN_PERIOD-1.
REQ-021 A spawn attempt SHALL set enable_count[sel] only if that bit is 0; if the bit is already 1, the attempt is dropped.
REQ-022 The block SHALL keep a registered copy prev_pos of row_pos, updated every cycle.
REQ-023 Wrap: for an enabled lane i with prev_pos[i]=15 and row_pos[i]=0, the block SHALL clear enable_count[i] and increment score by one.
REQ-024 Several lanes wrapping in the same cycle SHALL add the number of wrapping lanes to score.
REQ-025 Score SHALL saturate at 2^SCORE_W-1.
REQ-026 A wrap and a spawn on the same lane in the same cycle SHALL leave enable_count[i]=1; the counter still restarts from 0 via its own wrap.
REQ-027 Display: for each enabled lane i, red_pixels SHALL light row row_pos[i] at columns 2i and 2i+1.
REQ-028 Display: green_pixels SHALL light row 15 at columns 2*player_col and 2*player_col+1 in every state.
REQ-029 In HIT, red_pixels SHALL light all 16 columns of row 15 and no other pixels.
REQ-030 In IDLE, red_pixels SHALL be 0.
REQ-031 Pixel outputs SHALL be registered, with one cycle of latency from row_pos/player_col/state.
REQ-032 game_over SHALL be registered and asserted in the first cycle of HIT.
REQ-033 start while in PLAY SHALL be ignored.
REQ-034 Score SHALL hold its value in HIT and IDLE until the next PLAY entry.

Reset
REQ-035 While reset=1 at a CLK edge, the block SHALL load: state=IDLE, enable_count=0, score=0, red_pixels=0, green_pixels=0, game_over=0, spawn timer=0, prev_pos=0.
REQ-036 Under ASTEROID_LFSR_SPAWN_EN, reset SHALL also load LFSR=8'h01.
REQ-037 Under round-robin selection, reset SHALL also load the lane pointer to 0.
REQ-038 Reset SHALL take priority over start and all other inputs, including mid-game.

Configuration
REQ-039 With macro ASTEROID_LFSR_SPAWN_EN defined, sel SHALL be LFSR[2:0].
REQ-040 The LFSR SHALL be 8-bit Fibonacci with taps 8,6,5,4, advanced once per spawn attempt.
REQ-041 Without ASTEROID_LFSR_SPAWN_EN, sel SHALL be a 3-bit round-robin pointer (0,1,...,7,0).
REQ-042 The round-robin pointer SHALL be cleared on PLAY entry and advanced once per spawn attempt.

Verification (SPAWN_PERIOD=4, SCORE_W=8, macro undefined)
REQ-043 Reset, then start pulse -> state PLAY; enable_count=8'h01 after 4 cycles, 8'h03 after 8 cycles.
REQ-044 Lane 0 enabled, player_col=3, row_pos[3:0] driven 15 then 0 -> enable_count[0] cleared and score=1 on the next edge.
REQ-045 Lane 2 enabled, player_col=2, row_pos[11:8]=15 -> game_over=1 next cycle, enable_count=0, red_pixels row 15 = 16'hFFFF.
REQ-046 Lanes 1 and 5 wrapping in the same cycle -> score increases by 2.
REQ-047 Score preloaded to 255 plus one wrap -> score stays 255.
REQ-048 reset asserted mid-PLAY with enable_count=8'hFF -> all outputs 0 one edge later; start pulse then re-enters PLAY with score=0.
